conv_addr_gen: RTL and testbench

CONV_ADDR_GEN -- requirements
Module: conv_addr_gen

---
 rtl/conv_addr_gen_pkg.sv | 27 ++
 rtl/conv_addr_gen_if.sv | 26 ++
 rtl/conv_wr_delay.sv | 48 ++++
 rtl/conv_addr_gen.sv | 201 ++++++++++++++++++++
 tb/tb_conv_addr_gen.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_addr_gen_pkg.sv
// rtl/conv_addr_gen_pkg.sv - shared defaults, FSM encoding and output-size helper
// Purpose: common definitions imported by every conv_addr_gen file.
// Ports:   none (package).
package conv_addr_gen_pkg;

   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_IMG_W   = 16;
   localparam int DEF_IMG_H   = 16;
   localparam int DEF_K       = 4;
   localparam int DEF_NF      = 4;
   localparam int DEF_MAC_LAT = 2;

   // Loop counter width; comfortably wider than any image/filter dimension.
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } cag_state_t;

   // Number of output positions along one image dimension.
   function automatic int out_dim(input int img, input int k, input logic s2);
      return s2 ? ((img - k) / 2 + 1) : (img - k + 1);
   endfunction

endpackage

// File: rtl/conv_addr_gen_if.sv
// rtl/conv_addr_gen_if.sv - tap read and output write bus of the address generator
// Purpose: bundles the tap read handshake and the output write strobe.
// Ports:   master = generator side (drives addresses, flags, wr_en/wr_addr),
//          slave  = memory/MAC side (drives rd_ready).
interface conv_addr_gen_if #(
   parameter int ADDR_W = 10
);
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] img_addr;
   logic [ADDR_W-1:0] flt_addr;
   logic              mac_clr;
   logic              mac_last;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;

   modport master (
      output rd_valid, img_addr, flt_addr, mac_clr, mac_last, wr_en, wr_addr,
      input  rd_ready
   );

   modport slave (
      input  rd_valid, img_addr, flt_addr, mac_clr, mac_last, wr_en, wr_addr,
      output rd_ready
   );
endinterface

// File: rtl/conv_wr_delay.sv
// rtl/conv_wr_delay.sv - MAC_LAT-deep valid+address shift line for output writes
// Purpose: delays each finished-window output address by exactly MAC_LAT cycles.
// Ports:   clk, rst (async active-low), in_valid/in_addr (push side),
//          out_valid/out_addr (emerging write), pending (entries remain after this cycle).
module conv_wr_delay #(
   parameter int ADDR_W  = 10,
   parameter int MAC_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic              pending
);

   logic [MAC_LAT-1:0] vld;
   logic [ADDR_W-1:0]  addr [MAC_LAT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= '0;
         for (int k = 0; k < MAC_LAT; k++) addr[k] <= '0;
      end else begin
         vld[0]  <= in_valid;
         // Address is zeroed when empty so wr_addr reads 0 without a write.
         addr[0] <= in_valid ? in_addr : '0;
         for (int k = 1; k < MAC_LAT; k++) begin
            vld[k]  <= vld[k-1];
            addr[k] <= addr[k-1];
         end
      end
   end

   assign out_valid = vld[MAC_LAT-1];
   assign out_addr  = addr[MAC_LAT-1];

   // The last stage is leaving this cycle, so only earlier stages count.
   generate
      if (MAC_LAT > 1) begin : g_pend
         assign pending = |vld[MAC_LAT-2:0];
      end else begin : g_no_pend
         assign pending = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - convolution tap/filter/output address generator
// Purpose: walks f/r/c/i/j loops emitting image and filter tap addresses,
//          MAC window flags, and delayed output write addresses.
// Ports:   clk, rst (async active-low), start/stride2/img_base/flt_base/out_base
//          (job request, sampled in IDLE), bus (master: read taps + writes),
//          busy (job in progress), done (one-cycle end-of-job pulse).
module conv_addr_gen
   import conv_addr_gen_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int IMG_W   = DEF_IMG_W,
   parameter int IMG_H   = DEF_IMG_H,
   parameter int K       = DEF_K,
   parameter int NF      = DEF_NF,
   parameter int MAC_LAT = DEF_MAC_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stride2,
   input  logic [ADDR_W-1:0] img_base,
   input  logic [ADDR_W-1:0] flt_base,
   input  logic [ADDR_W-1:0] out_base,
   conv_addr_gen_if.master   bus,
   output logic              busy,
   output logic              done
);

   cag_state_t        state;
   logic              s2_q;
   logic [CNT_W-1:0]  oh_q, ow_q;
   logic [CNT_W-1:0]  f, r, c, i, j;
   logic [ADDR_W-1:0] img_base_q;
   logic [ADDR_W-1:0] row_org;     // img_base + r*S*IMG_W
   logic [ADDR_W-1:0] win_org;     // row_org + c*S
   logic [ADDR_W-1:0] tap_row;     // win_org + i*IMG_W
   logic [ADDR_W-1:0] img_addr_q;  // tap_row + j
   logic [ADDR_W-1:0] flt_fbase;   // flt_base + f*K*K
   logic [ADDR_W-1:0] flt_addr_q;
   logic [ADDR_W-1:0] out_addr_q;  // output address of the current window
   logic              rd_valid_q, busy_q, done_q;

   logic              accept, j_end, i_end, c_end, r_end, f_end, win_end, final_tap;
   logic [ADDR_W-1:0] nxt_tap, nxt_win, nxt_row;
   logic              wr_en_w, pending;
   logic [ADDR_W-1:0] wr_addr_w;

   assign accept    = rd_valid_q && bus.rd_ready;
   assign j_end     = (j == CNT_W'(K - 1));
   assign i_end     = (i == CNT_W'(K - 1));
   assign c_end     = (c == ow_q - CNT_W'(1));
   assign r_end     = (r == oh_q - CNT_W'(1));
   assign f_end     = (f == CNT_W'(NF - 1));
   assign win_end   = i_end && j_end;
   assign final_tap = win_end && c_end && r_end && f_end;

   assign nxt_tap = tap_row + ADDR_W'(IMG_W);
   assign nxt_win = win_org + (s2_q ? ADDR_W'(2) : ADDR_W'(1));
   assign nxt_row = row_org + (s2_q ? ADDR_W'(2 * IMG_W) : ADDR_W'(IMG_W));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         s2_q       <= 1'b0;
         oh_q       <= '0;
         ow_q       <= '0;
         f          <= '0;
         r          <= '0;
         c          <= '0;
         i          <= '0;
         j          <= '0;
         img_base_q <= '0;
         row_org    <= '0;
         win_org    <= '0;
         tap_row    <= '0;
         img_addr_q <= '0;
         flt_fbase  <= '0;
         flt_addr_q <= '0;
         out_addr_q <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_RUN;
                  busy_q     <= 1'b1;
                  rd_valid_q <= 1'b1;
                  s2_q       <= stride2;
                  oh_q       <= CNT_W'(out_dim(IMG_H, K, stride2));
                  ow_q       <= CNT_W'(out_dim(IMG_W, K, stride2));
                  f          <= '0;
                  r          <= '0;
                  c          <= '0;
                  i          <= '0;
                  j          <= '0;
                  img_base_q <= img_base;
                  row_org    <= img_base;
                  win_org    <= img_base;
                  tap_row    <= img_base;
                  img_addr_q <= img_base;
                  flt_fbase  <= flt_base;
                  flt_addr_q <= flt_base;
                  out_addr_q <= out_base;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (final_tap) begin
                     state      <= ST_DRAIN;
                     rd_valid_q <= 1'b0;
                     f          <= '0;
                     r          <= '0;
                     c          <= '0;
                     i          <= '0;
                     j          <= '0;
                     img_addr_q <= '0;
                     flt_addr_q <= '0;
                  end else if (!j_end) begin
                     j          <= j + CNT_W'(1);
                     img_addr_q <= img_addr_q + ADDR_W'(1);
                     flt_addr_q <= flt_addr_q + ADDR_W'(1);
                  end else if (!i_end) begin
                     j          <= '0;
                     i          <= i + CNT_W'(1);
                     tap_row    <= nxt_tap;
                     img_addr_q <= nxt_tap;
                     flt_addr_q <= flt_addr_q + ADDR_W'(1);
                  end else begin
                     j          <= '0;
                     i          <= '0;
                     out_addr_q <= out_addr_q + ADDR_W'(1);
                     if (!c_end) begin
                        c          <= c + CNT_W'(1);
                        win_org    <= nxt_win;
                        tap_row    <= nxt_win;
                        img_addr_q <= nxt_win;
                        flt_addr_q <= flt_fbase;
                     end else if (!r_end) begin
                        c          <= '0;
                        r          <= r + CNT_W'(1);
                        row_org    <= nxt_row;
                        win_org    <= nxt_row;
                        tap_row    <= nxt_row;
                        img_addr_q <= nxt_row;
                        flt_addr_q <= flt_fbase;
                     end else begin
                        // Next filter: its taps follow directly after this one's.
                        c          <= '0;
                        r          <= '0;
                        f          <= f + CNT_W'(1);
                        row_org    <= img_base_q;
                        win_org    <= img_base_q;
                        tap_row    <= img_base_q;
                        img_addr_q <= img_base_q;
                        flt_fbase  <= flt_addr_q + ADDR_W'(1);
                        flt_addr_q <= flt_addr_q + ADDR_W'(1);
                     end
                  end
               end
            end
            ST_DRAIN: begin
               // Leave when the only remaining entry (if any) is emerging now,
               // so done lands the cycle after the last wr_en.
               if (!pending) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   conv_wr_delay #(
      .ADDR_W  (ADDR_W),
      .MAC_LAT (MAC_LAT)
   ) u_wr_delay (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept && win_end),
      .in_addr   (out_addr_q),
      .out_valid (wr_en_w),
      .out_addr  (wr_addr_w),
      .pending   (pending)
   );

   assign bus.rd_valid = rd_valid_q;
   assign bus.img_addr = img_addr_q;
   assign bus.flt_addr = flt_addr_q;
   assign bus.mac_clr  = rd_valid_q && (i == '0) && (j == '0);
   assign bus.mac_last = rd_valid_q && win_end;
   assign bus.wr_en    = wr_en_w;
   assign bus.wr_addr  = wr_addr_w;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_conv_addr_gen.sv
// tb/tb_conv_addr_gen.sv - directed self-checking bench for conv_addr_gen
module tb_conv_addr_gen;
   import conv_addr_gen_pkg::*;

   localparam int ADDR_W  = 10;
   localparam int IMG_W   = 16;
   localparam int IMG_H   = 16;
   localparam int K       = 4;
   localparam int NF      = 4;
   localparam int MAC_LAT = 2;
   localparam int BUDGET  = 30000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              stride2 = 1'b0;
   logic [ADDR_W-1:0] img_base = '0;
   logic [ADDR_W-1:0] flt_base = '0;
   logic [ADDR_W-1:0] out_base = '0;
   logic              busy, done;

   conv_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

   conv_addr_gen #(
      .ADDR_W (ADDR_W), .IMG_W (IMG_W), .IMG_H (IMG_H),
      .K (K), .NF (NF), .MAC_LAT (MAC_LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stride2  (stride2),
      .img_base (img_base),
      .flt_base (flt_base),
      .out_base (out_base),
      .bus      (bus),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [ADDR_W-1:0] ex_img[$], ex_flt[$], ex_wr[$];
   bit                ex_clr[$], ex_last[$];
   logic [ADDR_W-1:0] ob_img[$], ob_flt[$], ob_wr[$];
   bit                ob_clr[$], ob_last[$];
   int                ob_wr_cyc[$], ob_last_cyc[$];
   int                ob_done_cyc, ob_done_cnt, ob_stall_chg;
   bit                ob_busy_start, ob_busy_end, ob_post_valid;

   task automatic build_model(input bit s2, input int ib, input int fb, input int obase);
      int s, oh, ow;
      ex_img.delete(); ex_flt.delete(); ex_wr.delete(); ex_clr.delete(); ex_last.delete();
      s  = s2 ? 2 : 1;
      oh = (IMG_H - K) / s + 1;
      ow = (IMG_W - K) / s + 1;
      for (int f = 0; f < NF; f++)
         for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++) begin
                     ex_img.push_back(ADDR_W'(ib + (r * s + i) * IMG_W + c * s + j));
                     ex_flt.push_back(ADDR_W'(fb + f * K * K + i * K + j));
                     ex_clr.push_back(i == 0 && j == 0);
                     ex_last.push_back(i == K - 1 && j == K - 1);
                  end
               ex_wr.push_back(ADDR_W'(obase + f * oh * ow + r * ow + c));
            end
   endtask

   // Drives one job and records what the DUT did; judging is left to the tests.
   task automatic run_job(input bit s2, input int ib, input int fb, input int obase,
                          input int ready_pct, input int abort_taps, input int poke_cyc);
      bit                prev_stall;
      logic [ADDR_W-1:0] p_img, p_flt;
      bit                p_clr, p_last;
      ob_img.delete(); ob_flt.delete(); ob_wr.delete(); ob_clr.delete(); ob_last.delete();
      ob_wr_cyc.delete(); ob_last_cyc.delete();
      ob_done_cyc = -1; ob_done_cnt = 0; ob_stall_chg = 0;
      ob_busy_start = 1'b0; ob_busy_end = 1'b1; ob_post_valid = 1'b0;
      prev_stall = 1'b0; p_img = '0; p_flt = '0; p_clr = 1'b0; p_last = 1'b0;
      stride2 = s2; img_base = ADDR_W'(ib); flt_base = ADDR_W'(fb); out_base = ADDR_W'(obase);
      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         @(negedge clk);
         start = (cyc == 0) || (poke_cyc > 0 && cyc == poke_cyc);
         if (poke_cyc > 0 && cyc == poke_cyc) begin
            stride2 = ~s2; img_base = ADDR_W'(ib + 7);
         end
         bus.rd_ready = ($urandom_range(99) < ready_pct);
         if (poke_cyc > 0 && bus.rd_valid && bus.rd_ready && ob_img.size() == ex_img.size() - 1)
            start = 1'b1;
         if (cyc == 1) ob_busy_start = busy;
         if (ob_done_cyc >= 0 && cyc == ob_done_cyc + 2) ob_busy_end = busy;
         if (ob_done_cyc >= 0 && cyc > ob_done_cyc && bus.rd_valid) ob_post_valid = 1'b1;
         if (prev_stall && bus.rd_valid &&
             {p_img, p_flt, p_clr, p_last} != {bus.img_addr, bus.flt_addr, bus.mac_clr, bus.mac_last})
            ob_stall_chg++;
         prev_stall = bus.rd_valid && !bus.rd_ready;
         p_img = bus.img_addr; p_flt = bus.flt_addr; p_clr = bus.mac_clr; p_last = bus.mac_last;
         if (bus.rd_valid && bus.rd_ready) begin
            ob_img.push_back(bus.img_addr);
            ob_flt.push_back(bus.flt_addr);
            ob_clr.push_back(bus.mac_clr);
            ob_last.push_back(bus.mac_last);
            if (bus.mac_last) ob_last_cyc.push_back(cyc);
         end
         if (bus.wr_en) begin
            ob_wr.push_back(bus.wr_addr);
            ob_wr_cyc.push_back(cyc);
         end
         if (done) begin
            ob_done_cnt++;
            if (ob_done_cyc < 0) ob_done_cyc = cyc;
         end
         if (abort_taps > 0 && ob_img.size() >= abort_taps) break;
         if (ob_done_cyc >= 0 && cyc >= ob_done_cyc + 4) break;
      end
      start = 1'b0;
   endtask

   function automatic int tap_errs();
      int e;
      e = (ob_img.size() == ex_img.size()) ? 0 : 1;
      for (int k = 0; k < int'(ob_img.size()) && k < int'(ex_img.size()); k++)
         if (ob_img[k] !== ex_img[k] || ob_flt[k] !== ex_flt[k] ||
             ob_clr[k] !== ex_clr[k] || ob_last[k] !== ex_last[k]) e++;
      return e;
   endfunction

   function automatic int wr_errs();
      int e;
      e = (ob_wr.size() == ex_wr.size()) ? 0 : 1;
      for (int k = 0; k < int'(ob_wr.size()) && k < int'(ex_wr.size()); k++)
         if (ob_wr[k] !== ex_wr[k]) e++;
      return e;
   endfunction

   function automatic int timing_errs();
      int e;
      e = (ob_wr_cyc.size() == ob_last_cyc.size()) ? 0 : 1;
      for (int k = 0; k < int'(ob_wr_cyc.size()) && k < int'(ob_last_cyc.size()); k++)
         if (ob_wr_cyc[k] != ob_last_cyc[k] + MAC_LAT) e++;
      return e;
   endfunction

   function automatic logic [3*ADDR_W+5:0] out_vec();
      return {bus.rd_valid, bus.img_addr, bus.flt_addr, bus.mac_clr, bus.mac_last,
              bus.wr_en, bus.wr_addr, busy, done};
   endfunction

   task automatic test_reset();
      bit active;
      bus.rd_ready = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (out_vec() !== '0) begin
         fails++; $display("FAIL reset_outputs: got %h expected 0", out_vec());
      end
      rst = 1'b1;
      active = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.rd_valid || busy || done || bus.wr_en) active = 1'b1;
      end
      tests++;
      if (active !== 1'b0) begin
         fails++; $display("FAIL idle_after_reset: got activity %0d expected 0", active);
      end
   endtask

   task automatic test_stride1();
      build_model(1'b0, 0, 512, 0);
      run_job(1'b0, 0, 512, 0, 100, 0, 0);
      tests++; if (ob_img.size() !== 10816) begin fails++; $display("FAIL s1_taps: got %0d expected 10816", ob_img.size()); end
      tests++; if (tap_errs() !== 0) begin fails++; $display("FAIL s1_tap_seq: got %0d errors expected 0", tap_errs()); end
      tests++; if (ob_wr.size() !== 676) begin fails++; $display("FAIL s1_writes: got %0d expected 676", ob_wr.size()); end
      tests++; if (ob_img[$] !== 10'd255) begin fails++; $display("FAIL s1_last_img: got %0d expected 255", ob_img[$]); end
      tests++; if (ob_flt[$] !== 10'd575) begin fails++; $display("FAIL s1_last_flt: got %0d expected 575", ob_flt[$]); end
      tests++; if (ob_wr[$] !== 10'd675) begin fails++; $display("FAIL s1_last_wr: got %0d expected 675", ob_wr[$]); end
      tests++; if (wr_errs() !== 0) begin fails++; $display("FAIL s1_wr_seq: got %0d errors expected 0", wr_errs()); end
      tests++; if (timing_errs() !== 0) begin fails++; $display("FAIL s1_wr_latency: got %0d errors expected 0", timing_errs()); end
      tests++; if (ob_done_cyc !== ob_wr_cyc[$] + 1 || ob_done_cnt !== 1) begin
         fails++; $display("FAIL s1_done: got cycle %0d count %0d expected cycle %0d count 1",
                           ob_done_cyc, ob_done_cnt, ob_wr_cyc[$] + 1);
      end
      tests++; if (ob_busy_start !== 1'b1 || ob_busy_end !== 1'b0) begin
         fails++; $display("FAIL s1_busy: got start %0d end %0d expected 1 0", ob_busy_start, ob_busy_end);
      end
   endtask

   task automatic test_stride2();
      build_model(1'b1, 0, 512, 0);
      run_job(1'b1, 0, 512, 0, 100, 0, 0);
      tests++; if (ob_img.size() !== 3136) begin fails++; $display("FAIL s2_taps: got %0d expected 3136", ob_img.size()); end
      tests++; if (ob_wr.size() !== 196) begin fails++; $display("FAIL s2_writes: got %0d expected 196", ob_wr.size()); end
      tests++; if (ob_img[128] !== 10'd34) begin fails++; $display("FAIL s2_win11_img: got %0d expected 34", ob_img[128]); end
      tests++; if (ob_wr[$] !== 10'd195) begin fails++; $display("FAIL s2_last_wr: got %0d expected 195", ob_wr[$]); end
      tests++; if (tap_errs() !== 0) begin fails++; $display("FAIL s2_tap_seq: got %0d errors expected 0", tap_errs()); end
   endtask

   task automatic test_random_ready();
      build_model(1'b0, 0, 512, 0);
      run_job(1'b0, 0, 512, 0, 50, 0, 0);
      tests++; if (tap_errs() !== 0) begin fails++; $display("FAIL rnd_tap_seq: got %0d errors expected 0", tap_errs()); end
      tests++; if (wr_errs() !== 0) begin fails++; $display("FAIL rnd_wr_seq: got %0d errors expected 0", wr_errs()); end
      tests++; if (timing_errs() !== 0) begin fails++; $display("FAIL rnd_wr_latency: got %0d errors expected 0", timing_errs()); end
      tests++; if (ob_stall_chg !== 0) begin fails++; $display("FAIL rnd_stall_hold: got %0d changes expected 0", ob_stall_chg); end
      tests++; if (ob_done_cnt !== 1) begin fails++; $display("FAIL rnd_done: got %0d pulses expected 1", ob_done_cnt); end
   endtask

   task automatic test_wrap();
      build_model(1'b1, 1000, 512, 0);
      run_job(1'b1, 1000, 512, 0, 100, 0, 0);
      tests++; if (ob_img[0] !== 10'd1000) begin fails++; $display("FAIL wrap_first: got %0d expected 1000", ob_img[0]); end
      tests++; if (ob_img[102] !== 10'd6) begin fails++; $display("FAIL wrap_offset30: got %0d expected 6", ob_img[102]); end
      tests++; if (tap_errs() !== 0) begin fails++; $display("FAIL wrap_tap_seq: got %0d errors expected 0", tap_errs()); end
   endtask

   task automatic test_reset_mid_job();
      bit active;
      build_model(1'b0, 0, 512, 0);
      run_job(1'b0, 0, 512, 0, 100, 500, 0);
      rst = 1'b0;
      #1;
      tests++;
      if (out_vec() !== '0) begin
         fails++; $display("FAIL midrst_outputs: got %h expected 0", out_vec());
      end
      active = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (out_vec() !== '0) active = 1'b1;
      end
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.wr_en || bus.rd_valid || busy || done) active = 1'b1;
      end
      tests++;
      if (active !== 1'b0) begin
         fails++; $display("FAIL midrst_stale: got activity %0d expected 0", active);
      end
      run_job(1'b0, 0, 512, 0, 100, 0, 0);
      tests++; if (ob_img[0] !== 10'd0 || ob_flt[0] !== 10'd512) begin
         fails++; $display("FAIL midrst_restart: got img %0d flt %0d expected 0 512", ob_img[0], ob_flt[0]);
      end
      tests++; if (tap_errs() !== 0 || wr_errs() !== 0) begin
         fails++; $display("FAIL midrst_rerun: got %0d tap and %0d write errors expected 0", tap_errs(), wr_errs());
      end
   endtask

   task automatic test_start_ignored();
      build_model(1'b0, 0, 512, 0);
      run_job(1'b0, 0, 512, 0, 100, 0, 100);
      tests++; if (tap_errs() !== 0) begin fails++; $display("FAIL poke_tap_seq: got %0d errors expected 0", tap_errs()); end
      tests++; if (ob_wr.size() !== 676) begin fails++; $display("FAIL poke_writes: got %0d expected 676", ob_wr.size()); end
      tests++; if (ob_done_cnt !== 1 || ob_post_valid !== 1'b0) begin
         fails++; $display("FAIL poke_no_rejob: got done %0d post_valid %0d expected 1 0", ob_done_cnt, ob_post_valid);
      end
   endtask

   initial begin
      bus.rd_ready = 1'b0;
      test_reset();
      test_stride1();
      test_stride2();
      test_random_ready();
      test_wrap();
      test_reset_mid_job();
      test_start_ignored();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
